sd_reg_master: RTL and testbench

//  Bus initiator for the controller's 8-bit byte-addressed register port
//  (we/addr/data_in/data_out). Turns one 32-bit register request into up to

---
 rtl/sd_reg_master.sv | 198 +++++++++++++++++++
 tb/tb_sd_reg_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_reg_master.sv
// sd_reg_master: turns one 32-bit register request into up to four byte
// accesses on an 8-bit byte-addressed register port and returns one 32-bit
// response. Writes go lane 3 down to lane 0 so byte-0 side effects fire last;
// reads go lane 0 up to lane 3. All outputs are registered.
module sd_reg_master #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned BUS_GAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata
);

    localparam int unsigned GapW = (BUS_GAP < 2) ? 1 : $clog2(BUS_GAP);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StGap,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-3:0]   hi_q, hi_d;
    logic [31:0]         wdata_q, wdata_d;
    // Lanes still to be accessed, excluding the one currently on the bus.
    logic [3:0]          pend_q, pend_d;
    logic [1:0]          lane_q, lane_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [7:0]          bus_wdata_q, bus_wdata_d;

    logic                issue;
    logic [3:0]          issue_mask;
    logic [1:0]          issue_lane;

    // The word-select bits of the request address are ignored.
    logic [1:0] unused_addr_lo;
    assign unused_addr_lo = req_addr[1:0];

    // Next lane to access: highest enabled for writes, lowest for reads.
    function automatic logic [1:0] pick_lane(input logic [3:0] mask, input logic wr);
        logic [1:0] lane;
        lane = 2'd0;
        if (wr) begin
            if (mask[3])      lane = 2'd3;
            else if (mask[2]) lane = 2'd2;
            else if (mask[1]) lane = 2'd1;
            else              lane = 2'd0;
        end else begin
            if (mask[0])      lane = 2'd0;
            else if (mask[1]) lane = 2'd1;
            else if (mask[2]) lane = 2'd2;
            else              lane = 2'd3;
        end
        return lane;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        hi_d        = hi_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q;
        lane_d      = lane_q;
        gap_d       = gap_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        bus_we_d    = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        issue       = 1'b0;
        issue_mask  = 4'b0000;
        issue_lane  = 2'd0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    hi_d        = req_addr[ADDR_W-1:2];
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    if (req_be == 4'b0000) begin
                        state_d     = StDone;
                        rsp_valid_d = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_mask = req_be;
                    end
                end
            end
            StAccess: begin
                if (!we_q) begin
                    rsp_rdata_d[{lane_q, 3'b000} +: 8] = bus_rdata;
                end
                if (pend_q == 4'b0000) begin
                    state_d     = StDone;
                    rsp_valid_d = 1'b1;
                    req_ready_d = 1'b1;
                end else if (BUS_GAP > 0) begin
                    state_d = StGap;
                    gap_d   = GapW'(BUS_GAP - 1);
                end else begin
                    issue      = 1'b1;
                    issue_mask = pend_q;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    issue      = 1'b1;
                    issue_mask = pend_q;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
        endcase

        // Start a bus cycle; we_d/hi_d/wdata_d hold either the fresh request
        // or the latched one, so both entry paths share this.
        if (issue) begin
            issue_lane  = pick_lane(issue_mask, we_d);
            lane_d      = issue_lane;
            pend_d      = issue_mask & ~(4'b0001 << issue_lane);
            state_d     = StAccess;
            req_ready_d = 1'b0;
            bus_we_d    = we_d;
            bus_addr_d  = {hi_d, issue_lane};
            if (we_d) begin
                bus_wdata_d = wdata_d[{issue_lane, 3'b000} +: 8];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            hi_q        <= '0;
            wdata_q     <= '0;
            pend_q      <= '0;
            lane_q      <= '0;
            gap_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            hi_q        <= hi_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
            lane_q      <= lane_d;
            gap_q       <= gap_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_sd_reg_master.sv
// Testbench for sd_reg_master: two instances (BUS_GAP=0 and BUS_GAP=2), each
// with a byte-memory slave. Table vectors, hand sequences for back-to-back,
// busy toggling and mid-write reset, then random requests against a
// request-level model.
module tb_sd_reg_master;

    localparam int unsigned AW = 7;

    logic clk;
    logic mem_clr;

    logic          rst       [2];
    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [3:0]    req_be    [2];
    logic [31:0]   req_wdata [2];
    logic          rsp_valid [2];
    logic [31:0]   rsp_rdata [2];
    logic          bus_we    [2];
    logic [AW-1:0] bus_addr  [2];
    logic [7:0]    bus_wdata [2];
    logic [7:0]    bus_rdata [2];

    logic [7:0] mem     [2][128];
    logic [7:0] ref_mem [2][128];
    int         rsp_cnt [2];
    int         exp_cnt [2];

    int n_cmp;
    int n_bad;

    typedef struct {
        int          g;
        logic        we;
        logic [6:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vt [7];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sd_reg_master #(
            .ADDR_W (AW),
            .BUS_GAP((g == 0) ? 0 : 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_be   (req_be[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .bus_we   (bus_we[g]),
            .bus_addr (bus_addr[g]),
            .bus_wdata(bus_wdata[g]),
            .bus_rdata(bus_rdata[g])
        );
        assign bus_rdata[g] = mem[g][bus_addr[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memories and response-pulse counters.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_clr) begin
                for (int a = 0; a < 128; a++) mem[g][a] <= 8'h00;
                rsp_cnt[g] <= 0;
            end else begin
                if (bus_we[g]) mem[g][bus_addr[g]] <= bus_wdata[g];
                if (rsp_valid[g]) rsp_cnt[g] <= rsp_cnt[g] + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int gap_of(input int g);
        return (g == 0) ? 0 : 2;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected read data straight from the model memory.
    function automatic logic [31:0] model_rdata(input int g, input logic [6:0] addr,
                                                input logic [3:0] be);
        logic [31:0] r;
        logic [6:0]  a;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            a = {addr[6:2], 2'(l)};
            if (be[l]) r[8*l +: 8] = ref_mem[g][a];
        end
        return r;
    endfunction

    // One request: accept, then check every cycle up to and past the response.
    task automatic run_req(input string tag, input int g, input logic we, input logic [6:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input int exp_lat);
        int   lanes[$];
        int   gp;
        int   k;
        logic is_bus;
        logic [6:0] a;
        gp = gap_of(g);
        if (we) begin
            for (int l = 3; l >= 0; l--) if (be[l]) lanes.push_back(l);
        end else begin
            for (int l = 0; l < 4; l++) if (be[l]) lanes.push_back(l);
        end
        chk($sformatf("%s ready_before", tag), req_ready[g], 1'b1);
        req_we[g]    = we;
        req_addr[g]  = addr;
        req_be[g]    = be;
        req_wdata[g] = wdata;
        req_valid[g] = 1'b1;
        tick();
        req_valid[g] = 1'b0;
        for (int c = 1; c <= exp_lat; c++) begin
            is_bus = 1'b0;
            k = 0;
            if (c < exp_lat && ((c - 1) % (gp + 1)) == 0) begin
                is_bus = 1'b1;
                k = (c - 1) / (gp + 1);
            end
            chk($sformatf("%s c%0d bus_we", tag, c), bus_we[g], is_bus && we);
            if (is_bus && k < lanes.size()) begin
                a = {addr[6:2], 2'(lanes[k])};
                chk($sformatf("%s c%0d bus_addr", tag, c), bus_addr[g], a);
                if (we) chk($sformatf("%s c%0d bus_wdata", tag, c), bus_wdata[g],
                            wdata[8*lanes[k] +: 8]);
            end
            chk($sformatf("%s c%0d rsp_valid", tag, c), rsp_valid[g], c == exp_lat);
            chk($sformatf("%s c%0d req_ready", tag, c), req_ready[g], c == exp_lat);
            if (c == 1 && exp_lat > 1)
                chk($sformatf("%s c1 rsp_rdata_clr", tag), rsp_rdata[g], 32'h0);
            if (c == exp_lat) chk($sformatf("%s rsp_rdata", tag), rsp_rdata[g], exp_rdata);
            if (c < exp_lat) tick();
        end
        exp_cnt[g]++;
        tick();
        chk($sformatf("%s after rsp_valid", tag), rsp_valid[g], 1'b0);
        chk($sformatf("%s after rsp_rdata_hold", tag), rsp_rdata[g], exp_rdata);
        chk($sformatf("%s rsp_count", tag), rsp_cnt[g], exp_cnt[g]);
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                a = {addr[6:2], 2'(l)};
                if (be[l]) ref_mem[g][a] = wdata[8*l +: 8];
            end
        end
    endtask

    initial begin
        logic        rw;
        logic [6:0]  ra;
        logic [3:0]  rb;
        logic [31:0] rd;
        int          n;
        int          lat;
        int          diffs;

        n_cmp = 0;
        n_bad = 0;
        for (int g = 0; g < 2; g++) begin
            exp_cnt[g]   = 0;
            rst[g]       = 1'b1;
            req_valid[g] = 1'b0;
            req_we[g]    = 1'b0;
            req_addr[g]  = '0;
            req_be[g]    = '0;
            req_wdata[g] = '0;
            for (int a = 0; a < 128; a++) ref_mem[g][a] = 8'h00;
        end
        mem_clr = 1'b1;

        vt[0] = '{0, 1'b1, 7'h00, 4'hF, 32'h11223344, 32'h00000000, 5};
        vt[1] = '{0, 1'b1, 7'h08, 4'hF, 32'hA3A2A1A0, 32'h00000000, 5};
        vt[2] = '{0, 1'b0, 7'h08, 4'hF, 32'h00000000, 32'hA3A2A1A0, 5};
        vt[3] = '{1, 1'b1, 7'h20, 4'b0101, 32'h55667788, 32'h00000000, 5};
        vt[4] = '{1, 1'b0, 7'h20, 4'b0000, 32'h00000000, 32'h00000000, 1};
        vt[5] = '{1, 1'b0, 7'h20, 4'hF, 32'h00000000, 32'h00660088, 11};
        vt[6] = '{0, 1'b0, 7'h01, 4'b0110, 32'h00000000, 32'h00223300, 3};

        tick();
        tick();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d reset req_ready", g), req_ready[g], 1'b1);
            chk($sformatf("g%0d reset rsp_valid", g), rsp_valid[g], 1'b0);
            chk($sformatf("g%0d reset rsp_rdata", g), rsp_rdata[g], 32'h0);
            chk($sformatf("g%0d reset bus_we", g), bus_we[g], 1'b0);
            chk($sformatf("g%0d reset bus_addr", g), bus_addr[g], 7'h00);
            chk($sformatf("g%0d reset bus_wdata", g), bus_wdata[g], 8'h00);
        end
        mem_clr = 1'b0;
        rst[0]  = 1'b0;
        rst[1]  = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_req($sformatf("vec%0d", i), vt[i].g, vt[i].we, vt[i].addr, vt[i].be,
                    vt[i].wdata, vt[i].rdata, vt[i].lat);
        end

        // Back-to-back: second request held valid and taken in the DONE cycle.
        req_we[0]    = 1'b0;
        req_addr[0]  = 7'h08;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        tick();
        req_we[0]    = 1'b1;
        req_addr[0]  = 7'h30;
        req_be[0]    = 4'b1000;
        req_wdata[0] = 32'h9A000000;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("b2b c%0d bus_addr", c), bus_addr[0], 7'(8 + c - 1));
            chk($sformatf("b2b c%0d bus_we", c), bus_we[0], 1'b0);
            chk($sformatf("b2b c%0d rsp_valid", c), rsp_valid[0], 1'b0);
            tick();
        end
        chk("b2b c5 rsp_valid", rsp_valid[0], 1'b1);
        chk("b2b c5 req_ready", req_ready[0], 1'b1);
        chk("b2b c5 rsp_rdata", rsp_rdata[0], 32'hA3A2A1A0);
        tick();
        req_valid[0] = 1'b0;
        chk("b2b c6 bus_we", bus_we[0], 1'b1);
        chk("b2b c6 bus_addr", bus_addr[0], 7'h33);
        chk("b2b c6 bus_wdata", bus_wdata[0], 8'h9A);
        chk("b2b c6 rsp_valid", rsp_valid[0], 1'b0);
        chk("b2b c6 rsp_rdata", rsp_rdata[0], 32'h0);
        tick();
        chk("b2b c7 rsp_valid", rsp_valid[0], 1'b1);
        tick();
        exp_cnt[0] += 2;
        chk("b2b rsp_count", rsp_cnt[0], exp_cnt[0]);
        ref_mem[0][7'h33] = 8'h9A;

        // req_valid toggled while busy must be ignored.
        req_we[1]    = 1'b0;
        req_addr[1]  = 7'h20;
        req_be[1]    = 4'b0101;
        req_valid[1] = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            req_valid[1] = (c % 2) == 1;
            req_we[1]    = 1'($urandom_range(0, 1));
            req_addr[1]  = 7'($urandom_range(0, 127));
            req_be[1]    = 4'hF;
            chk($sformatf("tog c%0d rsp_valid", c), rsp_valid[1], 1'b0);
            if (c == 1) chk("tog c1 bus_addr", bus_addr[1], 7'h20);
            if (c == 4) chk("tog c4 bus_addr", bus_addr[1], 7'h22);
            tick();
        end
        req_valid[1] = 1'b0;
        chk("tog c5 rsp_valid", rsp_valid[1], 1'b1);
        chk("tog c5 rsp_rdata", rsp_rdata[1], 32'h00660088);
        exp_cnt[1]++;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("tog idle%0d req_ready", c), req_ready[1], 1'b1);
            chk($sformatf("tog idle%0d bus_we", c), bus_we[1], 1'b0);
        end
        chk("tog rsp_count", rsp_cnt[1], exp_cnt[1]);

        // Reset seen at the edge that would open lane 2: only lane 3 lands.
        req_we[0]    = 1'b1;
        req_addr[0]  = 7'h10;
        req_be[0]    = 4'hF;
        req_wdata[0] = 32'hDEADBEEF;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        chk("rst c1 bus_we", bus_we[0], 1'b1);
        chk("rst c1 bus_addr", bus_addr[0], 7'h13);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rst c2 bus_we", bus_we[0], 1'b0);
        chk("rst c2 req_ready", req_ready[0], 1'b1);
        chk("rst c2 rsp_valid", rsp_valid[0], 1'b0);
        chk("rst c2 bus_addr", bus_addr[0], 7'h00);
        chk("rst c2 rsp_rdata", rsp_rdata[0], 32'h0);
        repeat (6) tick();
        chk("rst rsp_count", rsp_cnt[0], exp_cnt[0]);
        chk("rst mem lane3", mem[0][7'h13], 8'hDE);
        chk("rst mem lane2", mem[0][7'h12], 8'h00);
        ref_mem[0][7'h13] = 8'hDE;

        // Random requests against the model.
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 40; i++) begin
                rw = 1'($urandom_range(0, 1));
                ra = 7'($urandom_range(0, 127));
                rb = 4'($urandom_range(0, 15));
                rd = $urandom;
                n  = 0;
                for (int l = 0; l < 4; l++) if (rb[l]) n++;
                lat = (n == 0) ? 1 : n + (n - 1) * gap_of(g) + 1;
                run_req($sformatf("rnd g%0d #%0d", g, i), g, rw, ra, rb, rd,
                        rw ? 32'h0 : model_rdata(g, ra, rb), lat);
            end
        end

        for (int g = 0; g < 2; g++) begin
            diffs = 0;
            for (int a = 0; a < 128; a++) if (mem[g][a] !== ref_mem[g][a]) diffs++;
            chk($sformatf("g%0d final mem diffs", g), diffs, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
